// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch controller.
// Owns the PC, drives the instruction-memory request/ack handshake and loads
// the IF/ID pipeline register. A one-entry skid buffer catches a response that
// lands while the pipe is stalled, and a drop flag squashes a fetch that was
// already in flight when a redirect arrived.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   stall               hold IF/ID and PC
//   branch_taken        redirect pulse from EX (overrides stall)
//   branch_target       redirect address, bits [1:0] forced to 0
//   imem_req/imem_addr  fetch request and address (registered)
//   imem_ack/imem_rdata response strobe and instruction word
//   if_id_pc/pc4/instr  IF/ID contents
//   if_id_valid         IF/ID holds a live instruction
//
// state | meaning
// IDLE  | out of reset, no request yet
// FETCH | request to imem_addr outstanding (or being squashed when drop=1)
// HOLD  | response parked in skid buffer, waiting for stall to clear
module if_fetch_ctrl #(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc4,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] PC_RST     = RESET_PC & ALIGN_MASK;

    state_t               r_state, w_state_nxt;
    logic [PC_W-1:0]      r_pc, w_pc_nxt;
    logic                 r_drop, w_drop_nxt;
    logic                 r_req, w_req_nxt;
    logic [PC_W-1:0]      r_addr, w_addr_nxt;
    logic [INSTR_W-1:0]   r_skid_instr, w_skid_instr_nxt;
    logic [PC_W-1:0]      r_skid_pc, w_skid_pc_nxt;
    logic [PC_W-1:0]      r_id_pc, w_id_pc_nxt;
    logic [PC_W-1:0]      r_id_pc4, w_id_pc4_nxt;
    logic [INSTR_W-1:0]   r_id_instr, w_id_instr_nxt;
    logic                 r_id_valid, w_id_valid_nxt;

    logic [PC_W-1:0]      w_tgt;
    logic [PC_W-1:0]      w_pc4;
    logic [PC_W-1:0]      w_skid_pc4;

    assign w_tgt      = branch_target & ALIGN_MASK;
    assign w_pc4      = r_pc + PC_STEP;
    assign w_skid_pc4 = r_skid_pc + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= PC_RST;
            r_drop       <= 1'b0;
            r_req        <= 1'b0;
            r_addr       <= PC_RST;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_id_pc      <= '0;
            r_id_pc4     <= '0;
            r_id_instr   <= '0;
            r_id_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drop       <= w_drop_nxt;
            r_req        <= w_req_nxt;
            r_addr       <= w_addr_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_id_pc      <= w_id_pc_nxt;
            r_id_pc4     <= w_id_pc4_nxt;
            r_id_instr   <= w_id_instr_nxt;
            r_id_valid   <= w_id_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drop_nxt       = r_drop;
        w_req_nxt        = r_req;
        w_addr_nxt       = r_addr;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;
        w_id_pc_nxt      = r_id_pc;
        w_id_pc4_nxt     = r_id_pc4;
        w_id_instr_nxt   = r_id_instr;
        w_id_valid_nxt   = r_id_valid;

        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                w_req_nxt   = 1'b1;
                if (branch_taken) begin
                    w_pc_nxt   = w_tgt;
                    w_addr_nxt = w_tgt;
                end else begin
                    w_addr_nxt = r_pc;
                end
            end
            FETCH: begin
                if (r_drop) begin
                    // Squashing the stale request: address stays put until its
                    // ack, then the newest target is requested.
                    w_id_valid_nxt = 1'b0;
                    if (branch_taken) w_pc_nxt = w_tgt;
                    if (imem_ack) begin
                        w_drop_nxt = 1'b0;
                        w_addr_nxt = branch_taken ? w_tgt : r_pc;
                    end
                end else if (branch_taken) begin
                    w_pc_nxt       = w_tgt;
                    w_id_valid_nxt = 1'b0;
                    if (imem_ack) w_addr_nxt = w_tgt;
                    else          w_drop_nxt = 1'b1;
                end else if (imem_ack) begin
                    if (stall) begin
                        w_skid_instr_nxt = imem_rdata;
                        w_skid_pc_nxt    = r_pc;
                        w_req_nxt        = 1'b0;
                        w_state_nxt      = HOLD;
                    end else begin
                        w_id_pc_nxt    = r_pc;
                        w_id_pc4_nxt   = w_pc4;
                        w_id_instr_nxt = imem_rdata;
                        w_id_valid_nxt = 1'b1;
                        w_pc_nxt       = w_pc4;
                        w_addr_nxt     = w_pc4;
                    end
                end else if (!stall) begin
                    w_id_valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    w_pc_nxt         = w_tgt;
                    w_id_valid_nxt   = 1'b0;
                    w_skid_instr_nxt = '0;
                    w_skid_pc_nxt    = '0;
                    w_req_nxt        = 1'b1;
                    w_addr_nxt       = w_tgt;
                    w_state_nxt      = FETCH;
                end else if (!stall) begin
                    w_id_pc_nxt    = r_skid_pc;
                    w_id_pc4_nxt   = w_skid_pc4;
                    w_id_instr_nxt = r_skid_instr;
                    w_id_valid_nxt = 1'b1;
                    w_pc_nxt       = w_skid_pc4;
                    w_req_nxt      = 1'b1;
                    w_addr_nxt     = w_skid_pc4;
                    w_state_nxt    = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign if_id_pc    = r_id_pc;
    assign if_id_pc4   = r_id_pc4;
    assign if_id_instr = r_id_instr;
    assign if_id_valid = r_id_valid;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br, ack;
    logic [31:0] tgt;

    logic        req_a, req_b, valid_a, valid_b;
    logic [31:0] addr_a, addr_b, rdata_a, rdata_b;
    logic [31:0] pc_a, pc_b, pc4_a, pc4_b, instr_a, instr_b;

    int checks = 0;
    int errors = 0;
    logic use_b = 1'b0;

    vec_t va[$];
    vec_t vb[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    // Instruction memory model: word encodes its own address.
    assign rdata_a = 32'h2008_0000 | addr_a;
    assign rdata_b = 32'h2008_0000 | addr_b;

    if_fetch_ctrl #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(br),
        .branch_target(tgt), .imem_req(req_a), .imem_addr(addr_a),
        .imem_ack(ack), .imem_rdata(rdata_a), .if_id_pc(pc_a),
        .if_id_pc4(pc4_a), .if_id_instr(instr_a), .if_id_valid(valid_a)
    );

    if_fetch_ctrl #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(br),
        .branch_target(tgt), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(ack), .imem_rdata(rdata_b), .if_id_pc(pc_b),
        .if_id_pc4(pc4_b), .if_id_instr(instr_b), .if_id_valid(valid_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                                input logic a, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.ack = a;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        logic        o_req, o_valid;
        logic [31:0] o_addr, o_pc, o_pc4, o_instr;
        stall = v.stall; br = v.br; tgt = v.tgt; ack = v.ack;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o_req   = use_b ? req_b   : req_a;
        o_addr  = use_b ? addr_b  : addr_a;
        o_valid = use_b ? valid_b : valid_a;
        o_pc    = use_b ? pc_b    : pc_a;
        o_pc4   = use_b ? pc4_b   : pc4_a;
        o_instr = use_b ? instr_b : instr_a;
        chk($sformatf("v%0d%s req", idx, use_b ? "b" : "a"), {31'd0, o_req}, {31'd0, e.e_req});
        if (e.e_req)
            chk($sformatf("v%0d%s addr", idx, use_b ? "b" : "a"), o_addr, e.e_addr);
        chk($sformatf("v%0d%s valid", idx, use_b ? "b" : "a"), {31'd0, o_valid}, {31'd0, e.e_valid});
        if (e.e_valid) begin
            chk($sformatf("v%0d%s pc", idx, use_b ? "b" : "a"), o_pc, e.e_pc);
            chk($sformatf("v%0d%s pc4", idx, use_b ? "b" : "a"), o_pc4, e.e_pc + 32'd4);
            chk($sformatf("v%0d%s instr", idx, use_b ? "b" : "a"), o_instr, 32'h2008_0000 | e.e_pc);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; br = 1'b0; ack = 1'b0; tgt = '0;

        //        stall br  tgt           ack  req  addr          valid pc
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h0,     0, 32'h0));    // IDLE->FETCH
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h4,     1, 32'h0));
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h8,     1, 32'h4));
        va.push_back(mk(1, 0, 32'h0,     1,   0, 32'h0,     1, 32'h4));    // ack 0x8 into skid
        va.push_back(mk(1, 0, 32'h0,     1,   0, 32'h0,     1, 32'h4));
        va.push_back(mk(1, 0, 32'h0,     1,   0, 32'h0,     1, 32'h4));
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'hC,     1, 32'h8));    // skid drains
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h10,    1, 32'hC));
        va.push_back(mk(0, 0, 32'h0,     0,   1, 32'h10,    0, 32'h0));    // slow ack
        va.push_back(mk(0, 0, 32'h0,     0,   1, 32'h10,    0, 32'h0));
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h14,    1, 32'h10));
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h18,    1, 32'h14));
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h1C,    1, 32'h18));
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h20,    1, 32'h1C));
        va.push_back(mk(0, 1, 32'h103,   0,   1, 32'h20,    0, 32'h0));    // redirect, 0x20 in flight
        va.push_back(mk(0, 0, 32'h0,     0,   1, 32'h20,    0, 32'h0));
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h100,   0, 32'h0));    // stale ack dropped
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h104,   1, 32'h100));
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h108,   1, 32'h104));
        va.push_back(mk(1, 1, 32'h40,    1,   1, 32'h40,    0, 32'h0));    // redirect beats stall
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h44,    1, 32'h40));
        va.push_back(mk(0, 1, 32'h200,   0,   1, 32'h44,    0, 32'h0));    // double redirect
        va.push_back(mk(0, 1, 32'h300,   0,   1, 32'h44,    0, 32'h0));
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h300,   0, 32'h0));
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h304,   1, 32'h300));
        va.push_back(mk(1, 0, 32'h0,     0,   1, 32'h304,   1, 32'h300));  // stall, no ack
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h308,   1, 32'h304));
        va.push_back(mk(1, 0, 32'h0,     1,   0, 32'h0,     1, 32'h304));  // into HOLD
        va.push_back(mk(1, 1, 32'h80,    1,   1, 32'h80,    0, 32'h0));    // redirect from HOLD
        va.push_back(mk(0, 0, 32'h0,     1,   1, 32'h84,    1, 32'h80));

        vb.push_back(mk(0, 0, 32'h0,     1,   1, 32'hFFFF_FFF8, 0, 32'h0));
        vb.push_back(mk(0, 0, 32'h0,     1,   1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8));
        vb.push_back(mk(0, 0, 32'h0,     1,   1, 32'h0,         1, 32'hFFFF_FFFC));
        vb.push_back(mk(0, 0, 32'h0,     1,   1, 32'h4,         1, 32'h0));
        vb.push_back(mk(0, 0, 32'h0,     1,   1, 32'h8,         1, 32'h4));

        repeat (3) @(negedge clk);
        chk("rst req", {31'd0, req_a}, 32'd0);
        chk("rst addr", addr_a, 32'h0);
        chk("rst valid", {31'd0, valid_a}, 32'd0);
        chk("rst pc", pc_a, 32'h0);
        chk("rst pc4", pc4_a, 32'h0);
        chk("rst instr", instr_a, 32'h0);
        chk("rst addr_b", addr_b, 32'hFFFF_FFF8);

        rst_n = 1'b1;
        use_b = 1'b0;
        foreach (va[i]) run_vec(va[i], i);

        stall = 1'b0; br = 1'b0; ack = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        use_b = 1'b1;
        foreach (vb[i]) run_vec(vb[i], i);

        // Asynchronous reset pulse between clock edges.
        @(posedge clk);
        #2;
        chk("pre-rst valid_b", {31'd0, valid_b}, 32'd1);
        chk("pre-rst req_b", {31'd0, req_b}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async req_a", {31'd0, req_a}, 32'd0);
        chk("async req_b", {31'd0, req_b}, 32'd0);
        chk("async valid_a", {31'd0, valid_a}, 32'd0);
        chk("async valid_b", {31'd0, valid_b}, 32'd0);
        chk("async addr_b", addr_b, 32'hFFFF_FFF8);
        @(negedge clk);
        rst_n = 1'b1;
        ack = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
